// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches the iterative multiplier from execute, captures
// the 64-bit product into the architectural HI/LO pair, stalls decode while a
// product is pending and serves mfhi/mflo reads with a writeback bypass.
module muldiv_sequencer #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 48
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mult_e,
   input  logic               signed_e,
   input  logic               mult_d,
   input  logic               mf_req_d,
   input  logic               mf_sel_d,
   input  logic               mt_we_w,
   input  logic               mt_sel_w,
   input  logic [WIDTH-1:0]   mt_data_w,
   input  logic               mult_ready,
   input  logic               mult_done,
   input  logic [2*WIDTH-1:0] product,
   output logic               start_mult,
   output logic               mult_sign,
   output logic               stall_mult,
   output logic               busy,
   output logic [WIDTH-1:0]   mf_data_d,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic               err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clear;
   logic             err_set;
   logic             capture;

   // State register and the watchdog counter that runs while a product is pending
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (cnt_clear) begin
            cnt <= '0;
         end else if (state == WAIT && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Next-state logic, launch pulse and the conditions that raise the sticky error
   always_comb begin
      state_next = state;
      start_mult = 1'b0;
      mult_sign  = 1'b0;
      cnt_clear  = 1'b0;
      err_set    = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (mult_e) begin
               if (mult_ready) begin
                  start_mult = 1'b1;
                  mult_sign  = signed_e;
                  cnt_clear  = 1'b1;
                  state_next = WAIT;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         WAIT: begin
            if (mult_e) begin
               err_set = 1'b1;
            end
            if (mult_done) begin
               capture    = 1'b1;
               state_next = CAPT;
            end else if (cnt == CNT_LAST) begin
               err_set    = 1'b1;
               state_next = IDLE;
            end
         end
         CAPT: begin
            if (mult_e) begin
               err_set = 1'b1;
            end
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end

   // HI/LO update: a product capture takes priority over a coincident mthi/mtlo
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (capture) begin
         {hi, lo} <= product;
      end else if (mt_we_w) begin
         if (mt_sel_w) begin
            hi <= mt_data_w;
         end else begin
            lo <= mt_data_w;
         end
      end
   end

   // Decode-side read port with the writeback bypass, blocked while a product is pending
   always_comb begin
      mf_data_d = mf_sel_d ? hi : lo;
      if (mt_we_w && (mt_sel_w == mf_sel_d) && !busy) begin
         mf_data_d = mt_data_w;
      end
   end

   assign busy       = (state != IDLE);
   assign stall_mult = busy & (mult_d | mf_req_d);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized multiply sequences against a
// transaction-level model of HI/LO and the sticky error flag.
module tb_muldiv_sequencer;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 48;

   logic               clk = 1'b0;
   logic               reset;
   logic               mult_e;
   logic               signed_e;
   logic               mult_d;
   logic               mf_req_d;
   logic               mf_sel_d;
   logic               mt_we_w;
   logic               mt_sel_w;
   logic [WIDTH-1:0]   mt_data_w;
   logic               mult_ready;
   logic               mult_done;
   logic [2*WIDTH-1:0] product;
   logic               start_mult;
   logic               mult_sign;
   logic               stall_mult;
   logic               busy;
   logic [WIDTH-1:0]   mf_data_d;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               err;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] mhi;
   logic [31:0] mlo;
   logic        merr;

   muldiv_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .mult_e     (mult_e),
      .signed_e   (signed_e),
      .mult_d     (mult_d),
      .mf_req_d   (mf_req_d),
      .mf_sel_d   (mf_sel_d),
      .mt_we_w    (mt_we_w),
      .mt_sel_w   (mt_sel_w),
      .mt_data_w  (mt_data_w),
      .mult_ready (mult_ready),
      .mult_done  (mult_done),
      .product    (product),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .stall_mult (stall_mult),
      .busy       (busy),
      .mf_data_d  (mf_data_d),
      .hi         (hi),
      .lo         (lo),
      .err        (err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Full-width product of the two operands as the ISA defines mult/multu
   function automatic logic [63:0] refProduct(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land just after the edge, ready to drive inputs
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the multiplier-side handshake and let combinational outputs settle
   task automatic applyStimulus(input logic me, input logic sg, input logic md, input logic [63:0] prod);
      mult_e    = me;
      signed_e  = sg;
      mult_done = md;
      product   = prod;
      #1;
   endtask

   // Launch from IDLE and step into the first WAIT cycle
   task automatic launchOp(input logic sgn);
      mult_ready = 1'b1;
      applyStimulus(1'b1, sgn, 1'b0, {$urandom, $urandom});
      checkOutput("launch_start", start_mult, 1);
      checkOutput("launch_sign", mult_sign, sgn);
      tick();
      mult_ready = 1'b0;
      mult_e     = 1'b0;
   endtask

   // One full multiply transaction with the product arriving after lat WAIT cycles
   task automatic doMult(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic hold_mf, input logic hold_md, input logic sel);
      logic [63:0] exp;
      int          busy_cycles;
      exp         = refProduct(sgn, a, b);
      mf_req_d    = hold_mf;
      mult_d      = hold_md;
      mf_sel_d    = sel;
      busy_cycles = 0;
      checkOutput("idle_busy", busy, 0);
      launchOp(sgn);
      for (int i = 1; i <= lat; i++) begin
         if (i == lat) applyStimulus(1'b0, sgn, 1'b1, exp);
         else applyStimulus(1'b0, sgn, 1'b0, {$urandom, $urandom});
         if (busy === 1'b1) busy_cycles++;
         checkOutput("wait_start", start_mult, 0);
         checkOutput("wait_stall", stall_mult, hold_mf | hold_md);
         tick();
      end
      mult_ready = 1'b1;
      applyStimulus(1'b0, sgn, 1'b0, {$urandom, $urandom});
      if (busy === 1'b1) busy_cycles++;
      mhi = exp[63:32];
      mlo = exp[31:0];
      checkOutput("capt_hi", hi, mhi);
      checkOutput("capt_lo", lo, mlo);
      checkOutput("capt_stall", stall_mult, hold_mf | hold_md);
      tick();
      #1;
      checkOutput("busy_len", busy_cycles, lat + 1);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_stall", stall_mult, 0);
      checkOutput("done_mf", mf_data_d, sel ? mhi : mlo);
      checkOutput("done_err", err, merr);
      mf_req_d = 1'b0;
      mult_d   = 1'b0;
   endtask

   initial begin
      logic [31:0] d1;
      logic [31:0] d2;
      logic [63:0] p;
      reset      = 1'b1;
      mult_e     = 1'b0;
      signed_e   = 1'b0;
      mult_d     = 1'b0;
      mf_req_d   = 1'b0;
      mf_sel_d   = 1'b0;
      mt_we_w    = 1'b0;
      mt_sel_w   = 1'b0;
      mt_data_w  = '0;
      mult_ready = 1'b1;
      mult_done  = 1'b0;
      product    = '0;
      mhi        = '0;
      mlo        = '0;
      merr       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_hi", hi, 0);
      checkOutput("rst_lo", lo, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_stall", stall_mult, 0);
      checkOutput("rst_start", start_mult, 0);
      checkOutput("rst_mf", mf_data_d, 0);

      $display("[TB] signed -3 * 7 with mflo held in decode");
      doMult(1'b1, 32'hFFFF_FFFD, 32'd7, 33, 1'b1, 1'b0, 1'b0);
      checkOutput("t1_hi_const", hi, 32'hFFFF_FFFF);
      checkOutput("t1_lo_const", lo, 32'hFFFF_FFEB);

      $display("[TB] back-to-back multu");
      doMult(1'b0, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b1, 1'b1);
      checkOutput("t3a_hi_const", hi, 32'h1);
      checkOutput("t3a_lo_const", lo, 32'hFFFF_FFFE);
      doMult(1'b0, 32'd5, 32'd5, 1, 1'b0, 1'b0, 1'b0);
      checkOutput("t3b_hi_const", hi, 32'h0);
      checkOutput("t3b_lo_const", lo, 32'h19);
      checkOutput("t3_err", err, 0);

      $display("[TB] randomized operations");
      for (int n = 0; n < 10; n++) begin
         doMult(1'($urandom), $urandom, $urandom, int'($urandom_range(1, 30)),
                1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("[TB] mthi with bypass in IDLE");
      mt_we_w   = 1'b1;
      mt_sel_w  = 1'b1;
      mt_data_w = 32'h1234;
      mf_req_d  = 1'b1;
      mf_sel_d  = 1'b1;
      #1;
      checkOutput("t5_bypass", mf_data_d, 32'h1234);
      checkOutput("t5_stall", stall_mult, 0);
      tick();
      mt_we_w = 1'b0;
      mhi     = 32'h1234;
      #1;
      checkOutput("t5_hi", hi, mhi);
      checkOutput("t5_mf", mf_data_d, mhi);
      d1        = $urandom;
      mt_we_w   = 1'b1;
      mt_sel_w  = 1'b0;
      mt_data_w = d1;
      #1;
      checkOutput("mtlo_no_bypass", mf_data_d, mhi);
      tick();
      mt_we_w  = 1'b0;
      mf_req_d = 1'b0;
      mlo      = d1;
      #1;
      checkOutput("mtlo_lo", lo, mlo);

      $display("[TB] mt writes while busy and collision with capture");
      launchOp(1'b1);
      d1        = $urandom;
      mt_we_w   = 1'b1;
      mt_sel_w  = 1'b0;
      mt_data_w = d1;
      mf_req_d  = 1'b1;
      mf_sel_d  = 1'b0;
      #1;
      checkOutput("busy_no_bypass", mf_data_d, mlo);
      tick();
      mlo = d1;
      d2  = $urandom;
      p   = refProduct(1'b1, $urandom, $urandom);
      mt_sel_w  = 1'b1;
      mt_data_w = d2;
      applyStimulus(1'b0, 1'b1, 1'b1, p);
      checkOutput("wait_mt_lo", lo, mlo);
      tick();
      mt_we_w  = 1'b0;
      mf_req_d = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, {$urandom, $urandom});
      mhi = p[63:32];
      mlo = p[31:0];
      checkOutput("collide_hi", hi, mhi);
      checkOutput("collide_lo", lo, mlo);
      tick();

      $display("[TB] launch while busy");
      launchOp(1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, {$urandom, $urandom});
      checkOutput("viol_start", start_mult, 0);
      tick();
      merr = 1'b1;
      p    = refProduct(1'b0, $urandom, $urandom);
      applyStimulus(1'b0, 1'b0, 1'b1, p);
      checkOutput("viol_busy", busy, 1);
      checkOutput("viol_err", err, merr);
      tick();
      mult_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
      mhi = p[63:32];
      mlo = p[31:0];
      checkOutput("viol_capt_hi", hi, mhi);
      checkOutput("viol_capt_lo", lo, mlo);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mhi   = '0;
      mlo   = '0;
      merr  = 1'b0;
      #1;
      checkOutput("rst2_err", err, 0);
      checkOutput("rst2_hi", hi, 0);

      doMult(1'b1, $urandom, $urandom, 7, 1'b0, 1'b0, 1'b1);

      $display("[TB] watchdog timeout");
      launchOp(1'b0);
      for (int i = 1; i <= TIMEOUT; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
         if (i == 1 || i == TIMEOUT) checkOutput("to_busy", busy, 1);
         tick();
      end
      mult_ready = 1'b1;
      merr       = 1'b1;
      #1;
      checkOutput("to_idle", busy, 0);
      checkOutput("to_err", err, merr);
      checkOutput("to_hi", hi, mhi);
      checkOutput("to_lo", lo, mlo);

      $display("[TB] reset mid-WAIT then stray done");
      launchOp(1'b1);
      repeat (3) begin
         applyStimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mhi   = '0;
      mlo   = '0;
      merr  = 1'b0;
      mult_ready = 1'b1;
      #1;
      checkOutput("rmw_busy", busy, 0);
      checkOutput("rmw_hi", hi, 0);
      checkOutput("rmw_lo", lo, 0);
      checkOutput("rmw_err", err, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
      checkOutput("stray_busy", busy, 0);
      checkOutput("stray_hi", hi, 0);
      checkOutput("stray_lo", lo, 0);
      checkOutput("stray_err", err, 0);

      $display("[TB] launch while multiplier not ready");
      mult_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, {$urandom, $urandom});
      checkOutput("nr_start", start_mult, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
      merr = 1'b1;
      checkOutput("nr_busy", busy, 0);
      checkOutput("nr_err", err, merr);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
